// File: rtl/game_pkg.sv
// Shared game types and frame constants used by the round sequencer and renderer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } round_state_t;

  typedef logic [1:0] lives_t;

  localparam int DEF_DEATH_FRAMES = 90;
  localparam int DEF_BLINK_FRAMES = 8;

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advanced by frame ticks; expire marks the tick that consumes the last frame.
module frame_timer #(
  parameter int WIDTH = 7
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             expire
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset)
      value <= '0;
    else if (load)
      value <= load_value;
    else if (tick && value != '0)
      value <= value - WIDTH'(1);
  end

  assign expire = tick && (value == WIDTH'(1));

endmodule

// File: rtl/round_flow_ctrl.sv
// Round sequencer: idle, play, death animation, respawn/game over, win.
// Define ROUND_LIVES_EN to enable the lives counter and respawn path.
module round_flow_ctrl
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES     = DEF_DEATH_FRAMES,
  parameter int BLINK_FRAMES     = DEF_BLINK_FRAMES,
  parameter int DOOR_HOLD_FRAMES = 30,
  parameter int START_LIVES      = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  output logic       hazard_reset,
  output logic       freeze_players,
  output logic       death_blink,
  output logic [1:0] dead_who,
  output lives_t     lives,
  output logic [2:0] round_state
);

  localparam int         TIMER_W    = $clog2(DEATH_FRAMES + 1);
  localparam int         BLINK_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [7:0] DOOR_HOLD  = 8'(DOOR_HOLD_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  round_state_t       state;
  logic               start_prev;
  logic               start_edge;
  logic [7:0]         door_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               death_hit;
  logic               dying_tick;
  logic               timer_expire;
  logic               respawn;
  logic [TIMER_W-1:0] death_timer_unused;

  assign start_edge = start_btn & ~start_prev;
  // Hazard flags are still set during the respawn pulse; they clear one cycle later.
  assign death_hit  = (state == ST_PLAY) && !hazard_reset && (player1_dead || player2_dead);
  assign dying_tick = frame_tick && (state == ST_DYING);
  assign round_state = state;

  frame_timer #(.WIDTH(TIMER_W)) u_death_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .tick       (dying_tick),
    .load       (death_hit),
    .load_value (TIMER_W'(DEATH_FRAMES)),
    .value      (death_timer_unused),
    .expire     (timer_expire)
  );

`ifdef ROUND_LIVES_EN
  logic start_go;
  logic dying_done;

  assign start_go   = start_edge && (state == ST_IDLE || state == ST_OVER || state == ST_WIN);
  assign dying_done = (state == ST_DYING) && timer_expire;
  assign respawn    = lives > 2'd1;

  always_ff @(posedge Clk) begin
    if (Reset)
      lives <= '0;
    else if (start_go)
      lives <= lives_t'(START_LIVES);
    else if (dying_done)
      lives <= respawn ? lives - 2'd1 : '0;
  end
`else
  logic [1:0] unused_start_lives;

  assign unused_start_lives = 2'(START_LIVES);
  assign respawn = 1'b0;
  assign lives   = 2'd1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= ST_IDLE;
      hazard_reset   <= 1'b0;
      freeze_players <= 1'b1;
      death_blink    <= 1'b0;
      dead_who       <= 2'b00;
      door_cnt       <= '0;
      blink_cnt      <= '0;
      start_prev     <= 1'b0;
    end else begin
      start_prev   <= start_btn;
      // NOTE: default-then-override inside the clocked block keeps the pulse exactly one cycle wide.
      hazard_reset <= 1'b0;

      case (state)
        ST_IDLE, ST_OVER, ST_WIN: begin
          if (start_edge) begin
            state          <= ST_PLAY;
            hazard_reset   <= 1'b1;
            freeze_players <= 1'b0;
            dead_who       <= 2'b00;
            door_cnt       <= '0;
          end
        end

        ST_PLAY: begin
          if (hazard_reset)
            dead_who <= 2'b00;
          if (death_hit) begin
            state          <= ST_DYING;
            freeze_players <= 1'b1;
            dead_who       <= {player2_dead, player1_dead};
            blink_cnt      <= '0;
          end else if (frame_tick) begin
            if (player1_at_door && player2_at_door) begin
              if (door_cnt >= DOOR_HOLD - 8'd1) begin
                door_cnt       <= DOOR_HOLD;
                state          <= ST_WIN;
                freeze_players <= 1'b1;
              end else begin
                door_cnt <= door_cnt + 8'd1;
              end
            end else begin
              door_cnt <= '0;
            end
          end
        end

        ST_DYING: begin
          if (frame_tick) begin
            if (timer_expire) begin
              death_blink <= 1'b0;
              blink_cnt   <= '0;
              if (respawn) begin
                state          <= ST_PLAY;
                hazard_reset   <= 1'b1;
                freeze_players <= 1'b0;
              end else begin
                state <= ST_OVER;
              end
            end else if (blink_cnt == BLINK_LAST) begin
              blink_cnt   <= '0;
              death_blink <= ~death_blink;
            end else begin
              blink_cnt <= blink_cnt + BLINK_W'(1);
            end
          end
        end

        default: begin
          state          <= ST_IDLE;
          freeze_players <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_flow_ctrl.sv
// Self-checking bench for round_flow_ctrl: vector table plus scripted death sequences.
// Expectations follow the ROUND_LIVES_EN setting of the build.
module tb_round_flow_ctrl;
  import game_pkg::*;

  localparam int DF = 8;
  localparam int BF = 2;
  localparam int DH = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       player1_dead = 1'b0;
  logic       player2_dead = 1'b0;
  logic       player1_at_door = 1'b0;
  logic       player2_at_door = 1'b0;
  logic       hazard_reset;
  logic       freeze_players;
  logic       death_blink;
  logic [1:0] dead_who;
  logic [1:0] lives;
  logic [2:0] round_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       tick;
    logic       start;
    logic       p1d;
    logic       p2d;
    logic       d1;
    logic       d2;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] exp_q[$];
  string      tag_q[$];

  round_flow_ctrl #(
    .DEATH_FRAMES     (DF),
    .BLINK_FRAMES     (BF),
    .DOOR_HOLD_FRAMES (DH),
    .START_LIVES      (3)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .start_btn       (start_btn),
    .player1_dead    (player1_dead),
    .player2_dead    (player2_dead),
    .player1_at_door (player1_at_door),
    .player2_at_door (player2_at_door),
    .hazard_reset    (hazard_reset),
    .freeze_players  (freeze_players),
    .death_blink     (death_blink),
    .dead_who        (dead_who),
    .lives           (lives),
    .round_state     (round_state)
  );

  always #5 Clk = ~Clk;

  function automatic logic [1:0] exp_lives(input int n);
`ifdef ROUND_LIVES_EN
    return 2'(n);
`else
    return 2'd1;
`endif
  endfunction

  function automatic logic [9:0] o(input round_state_t st, input logic hz, input logic frz,
                                   input logic bl, input logic [1:0] who, input int lv);
    return {3'(st), hz, frz, bl, who, exp_lives(lv)};
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic tick, input logic start,
                              input logic p1d, input logic p2d, input logic d1, input logic d2,
                              input logic [9:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.tick = tick; v.start = start;
    v.p1d = p1d; v.p2d = p2d; v.d1 = d1; v.d2 = d2; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d hz=%b frz=%b blk=%b who=%b lives=%0d, want st=%0d hz=%b frz=%b blk=%b who=%b lives=%0d",
               name, got[9:7], got[6], got[5], got[4], got[3:2], got[1:0],
               exp[9:7], exp[6], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v);
    logic [9:0] got;
    logic [9:0] exp;
    string      tag;
    @(negedge Clk);
    Reset           = v.rst;
    frame_tick      = v.tick;
    start_btn       = v.start;
    player1_dead    = v.p1d;
    player2_dead    = v.p2d;
    player1_at_door = v.d1;
    player2_at_door = v.d2;
    exp_q.push_back(v.exp);
    tag_q.push_back(v.name);
    @(posedge Clk);
    #1;
    got = {round_state, hazard_reset, freeze_players, death_blink, dead_who, lives};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    check(tag, got, exp);
  endtask

  task automatic do_start();
    step(mk("start_edge", 0, 0, 1, 0, 0, 0, 0, o(ST_PLAY, 1, 0, 0, 2'b00, 3)));
    step(mk("start_held", 0, 0, 1, 0, 0, 0, 0, o(ST_PLAY, 0, 0, 0, 2'b00, 3)));
    step(mk("start_release", 0, 0, 0, 0, 0, 0, 0, o(ST_PLAY, 0, 0, 0, 2'b00, 3)));
  endtask

  task automatic die(input logic p1, input logic p2, input int lv, input bit respawn);
    logic [9:0] e;
    step(mk("death_entry", 0, 0, 0, p1, p2, 0, 0, o(ST_DYING, 0, 1, 0, {p2, p1}, lv)));
    for (int k = 1; k <= DF; k++) begin
      if (k < DF) begin
        e = o(ST_DYING, 0, 1, ((k / BF) % 2) != 0, {p2, p1}, lv);
        step(mk("dying_tick", 0, 1, 0, p1, p2, 0, 0, e));
        if (k == 3)
          step(mk("dying_hold", 0, 0, 0, p1, p2, 0, 0, e));
      end else if (respawn) begin
        step(mk("respawn", 0, 1, 0, p1, p2, 0, 0, o(ST_PLAY, 1, 0, 0, {p2, p1}, lv - 1)));
      end else begin
        step(mk("game_over", 0, 1, 0, p1, p2, 0, 0, o(ST_OVER, 0, 1, 0, {p2, p1}, 0)));
      end
    end
    if (respawn) begin
      step(mk("pulse_ignores_dead", 0, 0, 0, p1, p2, 0, 0, o(ST_PLAY, 0, 0, 0, 2'b00, lv - 1)));
      step(mk("after_respawn", 0, 0, 0, 0, 0, 0, 0, o(ST_PLAY, 0, 0, 0, 2'b00, lv - 1)));
    end
  endtask

  initial begin
    // name, rst, tick, start, p1d, p2d, door1, door2, expected outputs after the edge
    tbl.push_back(mk("reset0",        1, 0, 0, 0, 0, 0, 0, o(ST_IDLE,  0, 1, 0, 2'b00, 0)));
    tbl.push_back(mk("reset1",        1, 0, 0, 0, 0, 0, 0, o(ST_IDLE,  0, 1, 0, 2'b00, 0)));
    tbl.push_back(mk("start_edge",    0, 0, 1, 0, 0, 0, 0, o(ST_PLAY,  1, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("start_hold1",   0, 0, 1, 0, 0, 0, 0, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("start_hold2",   0, 0, 1, 0, 0, 0, 0, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("start_low",     0, 0, 0, 0, 0, 0, 0, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("start_in_play", 0, 0, 1, 0, 0, 0, 0, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_t1",       0, 1, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_notick",   0, 0, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_t2",       0, 1, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_drop",     0, 1, 0, 0, 0, 0, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_r1",       0, 1, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_r2",       0, 1, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_win",      0, 1, 0, 0, 0, 1, 1, o(ST_WIN,   0, 1, 0, 2'b00, 3)));
    tbl.push_back(mk("win_hold",      0, 1, 0, 0, 0, 1, 1, o(ST_WIN,   0, 1, 0, 2'b00, 3)));
    tbl.push_back(mk("win_restart",   0, 0, 1, 0, 0, 0, 0, o(ST_PLAY,  1, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_pulse_t",  0, 1, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("door_t2b",      0, 1, 0, 0, 0, 1, 1, o(ST_PLAY,  0, 0, 0, 2'b00, 3)));
    tbl.push_back(mk("death_beats_win", 0, 1, 0, 1, 0, 1, 1, o(ST_DYING, 0, 1, 0, 2'b01, 3)));
    tbl.push_back(mk("dying_t1",      0, 1, 0, 1, 0, 0, 0, o(ST_DYING, 0, 1, 0, 2'b01, 3)));
    tbl.push_back(mk("dying_t2",      0, 1, 0, 1, 0, 0, 0, o(ST_DYING, 0, 1, 1, 2'b01, 3)));
    tbl.push_back(mk("reset_mid_dying", 1, 1, 0, 1, 0, 0, 0, o(ST_IDLE, 0, 1, 0, 2'b00, 0)));
    tbl.push_back(mk("no_pulse_after_reset", 0, 0, 0, 0, 0, 0, 0, o(ST_IDLE, 0, 1, 0, 2'b00, 0)));

    foreach (tbl[i])
      step(tbl[i]);

    do_start();
`ifdef ROUND_LIVES_EN
    die(1'b1, 1'b0, 3, 1'b1);
    die(1'b0, 1'b1, 2, 1'b1);
    die(1'b1, 1'b1, 1, 1'b0);
`else
    die(1'b1, 1'b0, 3, 1'b0);
    do_start();
    die(1'b1, 1'b1, 3, 1'b0);
`endif
    step(mk("over_idle", 0, 1, 0, 0, 0, 0, 0, o(ST_OVER, 0, 1, 0, 2'b11, 0)));
    do_start();

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
